// File: rtl/grid_frame_scanner.sv
// grid_frame_scanner
// Paces display frames from a free-running frame counter, snapshots the
// playfield on each accepted frame tick and streams it cell by cell
// (row-major, x fastest) over a valid/ready handshake. draw_finish marks
// the end of each completed frame and opens the game-logic update window.
//
// state | meaning
// ------+-----------------------------------------------------------------
// WAIT  | idle between frames; the next frame tick starts a new stream
// SEND  | presenting snapshot cells; advance on every accepted handshake
// DONE  | one-cycle draw_finish pulse, then back to WAIT
//
// A tick that arrives in SEND or DONE is dropped and flagged in the sticky
// frame_overrun. The in-flight frame is never restarted.
module grid_frame_scanner #(
  parameter int X_SIZE       = 8,
  parameter int Y_SIZE       = 18,
  parameter int FRAME_CYCLES = 833333,
  parameter int CNT_W        = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [X_SIZE*Y_SIZE-1:0]   grid_data,
  output logic                       cell_valid,
  input  logic                       cell_ready,
  output logic [2:0]                 cell_x,
  output logic [4:0]                 cell_y,
  output logic                       cell_on,
  output logic                       frame_start,
  output logic                       draw_finish,
  output logic                       frame_overrun
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [2:0]       X_LAST   = 3'(X_SIZE - 1);
  localparam logic [4:0]       Y_LAST   = 5'(Y_SIZE - 1);

  logic [CNT_W-1:0]         frame_cnt;
  logic                     tick;
  logic [1:0]               state;
  logic [2:0]               x_q;
  logic [4:0]               y_q;
  logic [X_SIZE*Y_SIZE-1:0] snap;
  logic                     start_q;
  logic                     overrun_q;
  logic [7:0]               bit_idx;

  assign tick = (frame_cnt == CNT_LAST);

  // Free-running frame period counter; ignores handshake back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Frame sequencer: snapshot on tick in WAIT, walk cells on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_WAIT;
      x_q     <= '0;
      y_q     <= '0;
      snap    <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (tick) begin
            state   <= ST_SEND;
            snap    <= grid_data;
            x_q     <= '0;
            y_q     <= '0;
            start_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (cell_ready) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q   <= '0;
                state <= ST_DONE;
              end else begin
                y_q <= y_q + 5'd1;
              end
            end else begin
              x_q <= x_q + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_WAIT;
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

  // Sticky overrun: any tick that lands outside WAIT is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (tick && (state != ST_WAIT)) begin
      overrun_q <= 1'b1;
    end
  end

  // Row-major bit index; 8 columns per row, so y*8 is a shift (max 143).
  assign bit_idx = {y_q, 3'b000} + {5'b00000, x_q};

  assign cell_valid    = (state == ST_SEND);
  assign draw_finish   = (state == ST_DONE);
  assign cell_x        = x_q;
  assign cell_y        = y_q;
  assign cell_on       = snap[bit_idx];
  assign frame_start   = start_q;
  assign frame_overrun = overrun_q;

endmodule
